// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Byte width, drain FSM states and the SENT timeout.
package uart_pkg;

  localparam int UART_WIDTH   = 8;
  localparam int SENT_TIMEOUT = 4;

  typedef enum logic [1:0] {
    IDLE,
    SENT,
    BUSY
  } drain_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Dual-port byte storage for the echo FIFO.
// Synchronous write, combinational read.
import uart_pkg::*;

module uart_fifo_mem #(
  parameter int WIDTH      = UART_WIDTH,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  mclk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  // write port
  always_ff @(posedge mclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_fifo.sv
// Byte FIFO between uart_rx and uart_tx.
// Pops only when the transmitter is seen idle again.
import uart_pkg::*;

module uart_fifo #(
  parameter int WIDTH      = UART_WIDTH,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_strobe,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_strobe,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_MAX =
    (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [2:0] TMR_LAST =
    3'(SENT_TIMEOUT - 1);

  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2-1:0] rp;
  logic [WIDTH-1:0]      rd_data;
  logic                  push;
  logic                  pop;
  logic                  drop;
  drain_state_t          state;
  drain_state_t          state_nxt;
  logic [2:0]            tmr;

  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);
  assign pop   = (state == IDLE) && !empty && out_ready;
  assign push  = in_strobe && (!full || pop);
  assign drop  = in_strobe && full && !pop;

  uart_fifo_mem #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .mclk    (mclk),
    .wr_en   (push),
    .wr_addr (wp),
    .wr_data (in_data),
    .rd_addr (rp),
    .rd_data (rd_data)
  );

  // pointers, occupancy and sticky overflow
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  // registered byte and strobe toward the transmitter
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      out_data   <= '0;
      out_strobe <= 1'b0;
    end else begin
      out_strobe <= pop;
      if (pop) out_data <= rd_data;
    end
  end

  // drain state and time spent in SENT
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= (state == SENT) ? tmr + 1'b1 : '0;
    end
  end

  // drain next-state: wait for tx busy, then idle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pop) state_nxt = SENT;
      SENT: begin
        if (!out_ready)           state_nxt = BUSY;
        else if (tmr == TMR_LAST) state_nxt = IDLE;
      end
      BUSY: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
